// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO plus launch FSM feeding a constant-baud UART transmitter.
// Bytes are popped one at a time and handed over via tx_start/tx_data/tx_idle/tx_done.
module uart_tx_fifo_feeder #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_wr_en,
  input  logic [7:0]                   i_wr_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_overflow,
  output logic                         o_tx_start,
  output logic [7:0]                   o_tx_data,
  input  logic                         i_tx_idle,
  input  logic                         i_tx_done,
  output logic                         o_busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_GAP       = 2'd3
  } state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_overflow;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [GW-1:0] r_gap_cnt;
  logic [GW-1:0] w_gap_cnt_nxt;
  logic          r_tx_start;
  logic          w_tx_start_nxt;
  logic [7:0]    r_tx_data;
  logic [7:0]    w_tx_data_nxt;
  logic          r_busy;

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_nxt;

  // full is the registered flag, so a write while full is dropped even if a pop happens
  assign w_push = i_wr_en && !r_full;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == CW'(DEPTH));
      r_empty    <= (w_count_nxt == '0);
      r_overflow <= i_wr_en && r_full;
    end
  end

  // Launch FSM: next state and registered-output next values
  always_comb begin
    w_state_nxt    = r_state;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_pop          = 1'b0;
    w_tx_start_nxt = 1'b0;
    w_tx_data_nxt  = r_tx_data;
    case (r_state)
      S_IDLE: begin
        if (!r_empty && i_tx_idle) begin
          w_pop          = 1'b1;
          w_tx_data_nxt  = r_mem[r_rd_ptr];
          w_tx_start_nxt = 1'b1;
          w_state_nxt    = S_START;
        end
      end
      S_START: begin
        w_state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (i_tx_done) begin
          w_gap_cnt_nxt = '0;
          w_state_nxt   = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (32'(r_gap_cnt) == GAP_CYCLES - 32'd1) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_gap_cnt  <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;
  assign o_busy     = r_busy;

endmodule
